// File: rtl/agex_stage_ctrl.sv
// AGEX stage sequencer for the LC-3b pipeline. It holds the stage valid bit and latched IR,
// decodes the IR into AGEX mux selects and ALU op, and counts MEM back-pressure cycles.
package agex_pkg;
  typedef enum logic [1:0] {
    alu_add  = 2'd0,
    alu_and  = 2'd1,
    alu_not  = 2'd2,
    alu_pass = 2'd3
  } lc3b_aluop;
endpackage

module agex_stage_ctrl
  import agex_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int STALL_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_ir,
  output logic             in_ready,
  output logic             load_agex,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             load_mem,
  input  logic             flush,
  output logic             addr1mux_sel,
  output logic             addr2mux_sel2,
  output logic             addr2mux_sel1,
  output logic             lshf1_enable,
  output logic             addressmux_sel,
  output logic             sr2mux_sel,
  output logic             aluresultmux_sel,
  output lc3b_aluop        aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [15:0]      ir_q;
  logic [CNT_W-1:0] stall_q;

  // Handshake: a transfer happens on an edge where valid & ready are both high and flush is low.
  // Valid holds until taken; ready may depend combinationally on the downstream ready.
  assign in_ready  = (state_q == EMPTY) | out_ready;
  assign load_agex = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == FULL);
  assign load_mem  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load_agex) ir_q <= in_ir;
    end
  end

  // Flush beats a new accept, which beats a plain hand-off (so accept+hand-off stays FULL).
  always_comb begin
    state_d = state_q;
    if (flush)                       state_d = EMPTY;
    else if (load_agex)              state_d = FULL;
    else if (out_valid && out_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !flush) begin
      if (!(&stall_q)) stall_q <= stall_q + CNT_W'(1);
    end else begin
      stall_q <= '0;
    end
  end

  assign stall_cycles  = stall_q;
  assign stall_timeout = (stall_q >= CNT_W'(STALL_LIMIT));

  always_comb begin
    addr1mux_sel     = 1'b0;
    addr2mux_sel2    = 1'b0;
    addr2mux_sel1    = 1'b0;
    lshf1_enable     = 1'b0;
    addressmux_sel   = 1'b0;
    sr2mux_sel       = 1'b0;
    aluresultmux_sel = 1'b0;
    aluop            = alu_pass;
    illegal          = 1'b0;
    if (out_valid) begin
      unique case (ir_q[15:12])
        4'b0001: begin
          aluop            = alu_add;
          sr2mux_sel       = ir_q[5];
          aluresultmux_sel = 1'b1;
        end
        4'b0101: begin
          aluop            = alu_and;
          sr2mux_sel       = ir_q[5];
          aluresultmux_sel = 1'b1;
        end
        4'b1001: begin
          aluop            = alu_not;
          aluresultmux_sel = 1'b1;
        end
        4'b1101: ;
        4'b0000, 4'b1110: begin
          addr2mux_sel2  = 1'b1;
          lshf1_enable   = 1'b1;
          addressmux_sel = 1'b1;
        end
        4'b1100: begin
          addr1mux_sel   = 1'b1;
          addressmux_sel = 1'b1;
        end
        4'b0100: begin
          // JSR uses PC-relative offset11; JSRR jumps through SR1
          if (ir_q[11]) begin
            addr2mux_sel2 = 1'b1;
            addr2mux_sel1 = 1'b1;
            lshf1_enable  = 1'b1;
          end else begin
            addr1mux_sel  = 1'b1;
          end
          addressmux_sel = 1'b1;
        end
        4'b0010, 4'b0011: begin
          addr1mux_sel   = 1'b1;
          addr2mux_sel1  = 1'b1;
          addressmux_sel = 1'b1;
        end
        4'b0110, 4'b0111, 4'b1010, 4'b1011: begin
          addr1mux_sel   = 1'b1;
          addr2mux_sel1  = 1'b1;
          lshf1_enable   = 1'b1;
          addressmux_sel = 1'b1;
        end
        4'b1111: ;
        4'b1000: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
